// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types and 2-bit counter encodings
//
// Contents:
//   ctr2_t     2-bit saturating counter type
//   CTR_SNT    strong not-taken (00)
//   CTR_WNT    weak not-taken   (01)
//   CTR_WT     weak taken       (10)
//   CTR_ST     strong taken     (11)
//   CTR_RESET  reset value of every PHT entry (weak not-taken)
package bp_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT   = 2'b00;
    localparam ctr2_t CTR_WNT   = 2'b01;
    localparam ctr2_t CTR_WT    = 2'b10;
    localparam ctr2_t CTR_ST    = 2'b11;
    localparam ctr2_t CTR_RESET = CTR_WNT;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - next-state function of a 2-bit saturating direction counter
//
// Ports:
//   cur    in   current counter value
//   taken  in   resolved branch outcome
//   nxt    out  counter value after training (clamps at CTR_ST / CTR_SNT)
module sat_ctr2
    import bp_pkg::*;
(
    input  ctr2_t cur,
    input  logic  taken,
    output ctr2_t nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST) begin
                nxt = cur + 2'd1;
            end
        end else begin
            if (cur != CTR_SNT) begin
                nxt = cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch predictor: GHR xor PC indexes a PHT of 2-bit counters
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-low reset
//   pc_F, lookup_F, stall_F       fetch-side lookup request
//   predict_taken_F               combinational predicted direction
//   pred_idx_F, pred_ghr_F        index and pre-shift GHR, carried down the pipe to Decode
//   res_valid_D, res_taken_D,
//   res_pred_D, res_idx_D,
//   res_ghr_D                     decode-side resolution of a branch
//   mispredict_D                  combinational mispredict flag
//   branch_cnt, mispred_cnt       wrapping performance counters
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int GHR_BITS = 8,
    parameter int PHT_BITS = 8,
    parameter int PC_LSB   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_F,
    input  logic                lookup_F,
    input  logic                stall_F,
    output logic                predict_taken_F,
    output logic [PHT_BITS-1:0] pred_idx_F,
    output logic [GHR_BITS-1:0] pred_ghr_F,
    input  logic                res_valid_D,
    input  logic                res_taken_D,
    input  logic                res_pred_D,
    input  logic [PHT_BITS-1:0] res_idx_D,
    input  logic [GHR_BITS-1:0] res_ghr_D,
    output logic                mispredict_D,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispred_cnt
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;

    if (GHR_BITS < 1 || GHR_BITS > PHT_BITS) begin : g_bad_params
        $error("gshare_predictor: GHR_BITS must be in 1..PHT_BITS");
    end

    ctr2_t               pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr_r;
    logic [GHR_BITS-1:0] ghr_spec;
    logic [GHR_BITS-1:0] ghr_repair;
    logic [GHR_BITS-1:0] ghr_next;
    logic [31:0]         branch_cnt_r;
    logic [31:0]         mispred_cnt_r;
    ctr2_t               upd_ctr;
    logic                unused_ok;

    // Only the index slice of the PC matters; the rest is deliberately ignored.
    assign unused_ok = ^pc_F;

    // Lookup: zero-extended GHR folded into the PC slice; read is asynchronous
    // and sees the pre-update counter on a same-cycle collision.
    assign pred_idx_F      = pc_F[PC_LSB +: PHT_BITS] ^ PHT_BITS'(ghr_r);
    assign predict_taken_F = pht[pred_idx_F][1];
    assign pred_ghr_F      = ghr_r;

    assign mispredict_D = res_valid_D & (res_taken_D ^ res_pred_D);

    // With a 1-bit history the shift degenerates to loading the new bit.
    if (GHR_BITS == 1) begin : g_ghr_one
        assign ghr_spec   = predict_taken_F;
        assign ghr_repair = res_taken_D;
    end else begin : g_ghr_wide
        assign ghr_spec   = {ghr_r[GHR_BITS-2:0], predict_taken_F};
        assign ghr_repair = {res_ghr_D[GHR_BITS-2:0], res_taken_D};
    end

    // Repair wins: the fetch-side lookup in a mispredict cycle is being flushed.
    always_comb begin
        ghr_next = ghr_r;
        if (mispredict_D) begin
            ghr_next = ghr_repair;
        end else if (lookup_F && !stall_F) begin
            ghr_next = ghr_spec;
        end
    end

    sat_ctr2 u_upd_ctr (
        .cur   (pht[res_idx_D]),
        .taken (res_taken_D),
        .nxt   (upd_ctr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CTR_RESET;
            end
        end else if (res_valid_D) begin
            pht[res_idx_D] <= upd_ctr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_r <= '0;
        end else begin
            ghr_r <= ghr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_r  <= '0;
            mispred_cnt_r <= '0;
        end else begin
            if (res_valid_D) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end
            if (mispredict_D) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_r;
    assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_F;
    logic        lookup_F, stall_F;
    logic        predict_taken_F;
    logic [7:0]  pred_idx_F;
    logic [7:0]  pred_ghr_F;
    logic        res_valid_D, res_taken_D, res_pred_D;
    logic [7:0]  res_idx_D, res_ghr_D;
    logic        mispredict_D;
    logic [31:0] branch_cnt, mispred_cnt;

    int errors = 0;
    int checks = 0;
    logic chk_en   = 1'b0;
    logic wrap_req = 1'b0;

    // Reference model: plain integers, counters kept as 0..3.
    int          pht_m [256];
    int          ghr_m;
    logic [31:0] bc_m;
    logic [31:0] mc_m;

    gshare_predictor #(.GHR_BITS(8), .PHT_BITS(8), .PC_LSB(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_F            (pc_F),
        .lookup_F        (lookup_F),
        .stall_F         (stall_F),
        .predict_taken_F (predict_taken_F),
        .pred_idx_F      (pred_idx_F),
        .pred_ghr_F      (pred_ghr_F),
        .res_valid_D     (res_valid_D),
        .res_taken_D     (res_taken_D),
        .res_pred_D      (res_pred_D),
        .res_idx_D       (res_idx_D),
        .res_ghr_D       (res_ghr_D),
        .mispredict_D    (mispredict_D),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(logic [31:0] pc, int g);
        return ((pc >> 2) & 32'hFF) ^ g;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) pht_m[i] <= 1;
            ghr_m <= 0;
            bc_m  <= '0;
            mc_m  <= '0;
        end else begin
            automatic int ix = m_idx(pc_F, ghr_m);
            automatic int p  = (pht_m[ix] >= 2) ? 1 : 0;
            automatic int t  = res_taken_D ? 1 : 0;
            if (res_valid_D) begin
                bc_m <= bc_m + 32'd1;
                if (res_taken_D) pht_m[res_idx_D] <= (pht_m[res_idx_D] == 3) ? 3 : pht_m[res_idx_D] + 1;
                else             pht_m[res_idx_D] <= (pht_m[res_idx_D] == 0) ? 0 : pht_m[res_idx_D] - 1;
            end
            if (res_valid_D && (res_taken_D != res_pred_D)) begin
                mc_m  <= mc_m + 32'd1;
                ghr_m <= ((int'(res_ghr_D) * 2) + t) % 256;
            end else if (lookup_F && !stall_F) begin
                ghr_m <= ((ghr_m * 2) + p) % 256;
            end
            if (wrap_req) bc_m <= 32'hFFFF_FFFF;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int ix = m_idx(pc_F, ghr_m);
            chk("m_idx",   32'(pred_idx_F),      32'(ix));
            chk("m_pred",  32'(predict_taken_F), (pht_m[ix] >= 2) ? 32'd1 : 32'd0);
            chk("m_ghr",   32'(pred_ghr_F),      32'(ghr_m));
            chk("m_misp",  32'(mispredict_D),    (res_valid_D && (res_taken_D != res_pred_D)) ? 32'd1 : 32'd0);
            chk("m_bcnt",  branch_cnt,           bc_m);
            chk("m_mcnt",  mispred_cnt,          mc_m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(logic v, logic t, logic p, logic [7:0] idx, logic [7:0] g);
        res_valid_D = v;
        res_taken_D = t;
        res_pred_D  = p;
        res_idx_D   = idx;
        res_ghr_D   = g;
    endtask

    initial begin
        reset = 1'b0;
        pc_F = '0; lookup_F = 0; stall_F = 0;
        resolve(0, 0, 0, 8'h00, 8'h00);
        repeat (2) step();
        chk_en = 1'b1;
        reset  = 1'b1;

        // Reset values
        pc_F = 32'h40; lookup_F = 1; stall_F = 1;
        @(negedge clk);
        chk("rst_pred", 32'(predict_taken_F), 32'd0);
        chk("rst_idx",  32'(pred_idx_F),      32'h10);
        chk("rst_ghr",  32'(pred_ghr_F),      32'h00);
        chk("rst_bcnt", branch_cnt,           32'd0);

        // Training: two taken resolves with wrong prediction
        step();
        lookup_F = 0; stall_F = 0;
        resolve(1, 1, 0, 8'h10, 8'h00);
        @(negedge clk);
        chk("train_misp", 32'(mispredict_D), 32'd1);
        step();
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        pc_F = 32'h44;
        @(negedge clk);
        chk("train_ghr",  32'(pred_ghr_F),      32'h01);
        chk("train_idx",  32'(pred_idx_F),      32'h10);
        chk("train_pred", 32'(predict_taken_F), 32'd1);
        chk("train_mcnt", mispred_cnt,          32'd2);

        // Saturation at strong taken, then one not-taken
        step();
        resolve(1, 1, 1, 8'h10, 8'h00);
        repeat (5) step();
        resolve(1, 0, 1, 8'h10, 8'h00);
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        pc_F = 32'h40;
        @(negedge clk);
        chk("sat_ghr",  32'(pred_ghr_F),      32'h00);
        chk("sat_pred", 32'(predict_taken_F), 32'd1);

        // Clamp at strong not-taken
        step();
        resolve(1, 0, 0, 8'h20, 8'h00);
        repeat (3) step();
        resolve(1, 1, 1, 8'h20, 8'h00);
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        pc_F = 32'h80;
        @(negedge clk);
        chk("clamp_pred0", 32'(predict_taken_F), 32'd0);
        step();
        resolve(1, 1, 1, 8'h20, 8'h00);
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("clamp_pred1", 32'(predict_taken_F), 32'd1);
        chk("clamp_bcnt",  branch_cnt,           32'd13);

        // Repair overrides a same-cycle speculative shift
        step();
        pc_F = 32'h100; lookup_F = 1; stall_F = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spec_pred", 32'(predict_taken_F), 32'd0);
            chk("spec_ghr",  32'(pred_ghr_F),      32'h00);
            step();
        end
        resolve(1, 1, 0, 8'h33, 8'h05);
        @(negedge clk);
        chk("rep_misp", 32'(mispredict_D), 32'd1);
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        lookup_F = 0;
        @(negedge clk);
        chk("rep_ghr", 32'(pred_ghr_F), 32'h0B);

        // Stall holds the GHR; same-cycle collision sees the old counter
        step();
        lookup_F = 1; stall_F = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) resolve(1, 1, 1, 8'h4B, 8'h00);
            @(negedge clk);
            chk("stall_ghr",  32'(pred_ghr_F),      32'h0B);
            chk("stall_idx",  32'(pred_idx_F),      32'h4B);
            chk("stall_pred", 32'(predict_taken_F), 32'd0);
            step();
        end
        resolve(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("coll_pred", 32'(predict_taken_F), 32'd1);
        chk("coll_ghr",  32'(pred_ghr_F),      32'h0B);

        // Counter wrap
        step();
        lookup_F = 0; stall_F = 0;
        chk_en   = 1'b0;
        wrap_req = 1'b1;
        force dut.branch_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_r;
        step();
        wrap_req = 1'b0;
        chk_en   = 1'b1;
        resolve(1, 1, 1, 8'h55, 8'h00);
        @(negedge clk);
        chk("wrap_pre", branch_cnt, 32'hFFFF_FFFF);
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("wrap_post", branch_cnt, 32'd0);

        // Mid-cycle asynchronous reset
        step();
        resolve(1, 1, 0, 8'h66, 8'h07);
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_bcnt", branch_cnt,       32'd0);
        chk("arst_mcnt", mispred_cnt,      32'd0);
        chk("arst_ghr",  32'(pred_ghr_F), 32'h00);
        step();
        step();
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            if (n == 1500) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            pc_F     = $urandom & 32'h0000_0FFC;
            lookup_F = ($urandom_range(0, 3) != 0);
            stall_F  = ($urandom_range(0, 4) == 0);
            res_valid_D = ($urandom_range(0, 2) != 0);
            res_taken_D = ($urandom_range(0, 2) != 0);
            res_pred_D  = ($urandom_range(0, 3) != 0) ? res_taken_D : !res_taken_D;
            res_idx_D   = ($urandom_range(0, 3) == 0) ? 8'(m_idx(pc_F, ghr_m)) : 8'($urandom_range(0, 255));
            res_ghr_D   = 8'($urandom_range(0, 255));
        end
        step();
        resolve(0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
